// File: rtl/bs_mod_mul_pkg.sv
// bs_mod_mul_pkg: shared defaults and reduce() width for the bit-serial modular multiplier
package bs_mod_mul_pkg;
  localparam int LEN_DEF = 5;
  localparam int MOD_DEF = 29;
  localparam int RED_EXTRA = 2;
  localparam int RED_W_DEF = LEN_DEF + RED_EXTRA;
  function automatic int red_w(input int len);
    return len + RED_EXTRA;
  endfunction
endpackage

// File: rtl/bs_mod_red.sv
// bs_mod_red: combinational conditional subtraction of MOD, result cast to OW bits
module bs_mod_red #(
  parameter int IW = 7,
  parameter int OW = 7,
  parameter int MOD = 29
) (
  input  logic [IW-1:0] x,
  output logic [OW-1:0] y
);
  logic [IW-1:0] d;
  assign d = x - IW'(MOD);
  assign y = OW'((x >= IW'(MOD)) ? d : x);
endmodule

// File: rtl/bs_mod_mul.sv
// bs_mod_mul: serial-in (MSB first) modular multiply by a parallel b, Horner accumulation,
// serial 2*LEN-bit result out; the first output cycle is cancelled by a coinciding isync.
module bs_mod_mul import bs_mod_mul_pkg::*; #(
  parameter int LEN = LEN_DEF,
  parameter int MOD = MOD_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           a,
  input  logic [LEN-1:0] b,
  input  logic           isync,
  output logic           q,
  output logic           osync
);
  localparam int RW = red_w(LEN);
  localparam int CW = $clog2(3*LEN);
  logic [LEN-1:0] b_r, b_red, b_sel, acc, acc_next;
  logic [RW-1:0] sum, sum1;
  logic [CW-1:0] cnt;
  logic act, pend, last;
  logic [2*LEN-1:0] sr;
  bs_mod_red #(.IW(LEN), .OW(LEN), .MOD(MOD)) u_b  (.x(b),    .y(b_red));
  bs_mod_red #(.IW(RW),  .OW(RW),  .MOD(MOD)) u_r1 (.x(sum),  .y(sum1));
  bs_mod_red #(.IW(RW),  .OW(LEN), .MOD(MOD)) u_r2 (.x(sum1), .y(acc_next));
  assign b_sel = isync ? b_red : b_r;
  assign sum = (isync ? RW'(0) : RW'({acc, 1'b0})) + (a ? RW'(b_sel) : RW'(0));
  assign last = act & (cnt == CW'(LEN-1));
  // the upper LEN result bits are zero, so q is 0 while osync marks the frame start
  assign osync = pend & ~isync & ~reset;
  assign q = sr[2*LEN-1] & ~osync;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      b_r  <= '0;
      cnt  <= '0;
      act  <= 1'b0;
      pend <= 1'b0;
      sr   <= '0;
    end else begin
      if (isync | act) acc <= acc_next;
      if (isync) b_r <= b_red;
      cnt  <= isync ? CW'(1) : act ? cnt + CW'(1) : cnt;
      act  <= isync | (act & ~last);
      pend <= ~isync & last;
      sr   <= osync ? {{(LEN-1){1'b0}}, acc, 1'b0} : sr << 1;
    end
  end
endmodule

// File: tb/tb_bs_mod_mul.sv
// tb_bs_mod_mul: serial source -> bs_mod_mul -> serial collector, checked against (a*b) mod MOD
module tb_bs_mod_mul;
  import bs_mod_mul_pkg::*;
  localparam int LEN = LEN_DEF;
  localparam int MOD = MOD_DEF;
  logic clk = 1'b0, reset, a, isync, q, osync;
  logic [LEN-1:0] b;
  int checks = 0, errors = 0, cyc = 0, col_cnt = 0, osync_cyc = 0, osync_n = 0;
  bit q_stray = 1'b0;
  logic [2*LEN-1:0] col_sh;
  logic [2*LEN-1:0] res_q[$];
  int res_t[$];

  bs_mod_mul #(.LEN(LEN), .MOD(MOD)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .isync(isync), .q(q), .osync(osync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (osync) begin
      osync_n++;
      col_sh = '0;
      col_sh[0] = q;
      col_cnt = 1;
      osync_cyc = cyc;
    end else if (col_cnt > 0) begin
      col_sh = {col_sh[2*LEN-2:0], q};
      col_cnt++;
    end else if (q === 1'b1) q_stray = 1'b1;
    if (col_cnt == 2*LEN) begin
      res_q.push_back(col_sh);
      res_t.push_back(osync_cyc);
      col_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int av, input int bv);
    return (av * bv) % MOD;
  endfunction

  task automatic send(input logic [LEN-1:0] av, input logic [LEN-1:0] bv, input int rst_at, output int t0);
    t0 = 0;
    for (int i = 0; i < LEN; i++) begin
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      isync = (i == 0);
      b = bv;
      a = av[LEN-1-i];
      reset = (i == rst_at);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      isync = 1'b0;
      reset = 1'b0;
      a = 1'($urandom);
    end
  endtask

  task automatic pop_check(input string tag, input int av, input int bv, input int t0);
    if (res_q.size() == 0) check({tag, "_missing"}, 0, 1);
    else begin
      check({tag, "_val"}, 32'(res_q.pop_front()), model(av, bv));
      check({tag, "_lat"}, res_t.pop_front(), t0 + LEN);
    end
  endtask

  task automatic run(input int av, input int bv, input string tag);
    int t0, n0;
    n0 = osync_n;
    send(LEN'(av), LEN'(bv), -1, t0);
    idle(64 - LEN);
    check({tag, "_nosync"}, osync_n - n0, 1);
    pop_check(tag, av, bv, t0);
  endtask

  initial begin
    int av_d[7] = '{1, 2, 10, 31, 28, 0, 31};
    int bv_d[7] = '{16, 16, 16, 31, 28, 31, 0};
    int t0, t1, n0;
    reset = 1'b1; a = 1'b0; b = '0; isync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_q", q, 0);
    check("rst_osync", osync, 0);
    idle(2);
    for (int i = 0; i < 7; i++) run(av_d[i], bv_d[i], $sformatf("dir%0d", i));
    // reset in the fourth bit cycle kills the frame
    n0 = osync_n;
    send(LEN'(5), LEN'(16), 3, t0);
    idle(64 - LEN);
    check("rstab_osync", osync_n - n0, 0);
    check("rstab_res", res_q.size(), 0);
    run(5, 16, "after_rst");
    // restart exactly at the first output cycle: only the second result appears
    n0 = osync_n;
    send(LEN'(3), LEN'(16), -1, t0);
    send(LEN'(4), LEN'(16), -1, t1);
    idle(64 - LEN);
    check("b2b_n", osync_n - n0, 1);
    pop_check("b2b", 4, 16, t1);
    // isync during an output frame that finishes later leaves that frame intact
    send(LEN'(19), LEN'(23), -1, t0);
    idle(LEN + 3);
    send(LEN'(27), LEN'(30), -1, t1);
    idle(64 - LEN);
    check("ovl_n", res_q.size(), 2);
    pop_check("ovl1", 19, 23, t0);
    pop_check("ovl2", 27, 30, t1);
    for (int i = 0; i < 20; i++)
      run(int'($urandom_range(0, (1 << LEN) - 1)), int'($urandom_range(0, (1 << LEN) - 1)), $sformatf("rnd%0d", i));
    check("q_stray", 32'(q_stray), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
